// File: rtl/bsg_clk_gen_pearl_monitor_meter.sv
// Counts rising edges of an asynchronous monitor clock over a window of clk_i cycles.
// Define BSG_CLK_GEN_PEARL_MONITOR_METER_CONTINUOUS_EN to restart a window on each accepted result.
module bsg_clk_gen_pearl_monitor_meter #(
   parameter int window_width_p = 16,
   parameter int count_width_p  = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      clk_monitor_i,
   input  logic [window_width_p-1:0] window_cycles_i,
   input  logic                      start_i,
   output logic                      busy_o,
   output logic                      v_o,
   output logic [count_width_p-1:0]  count_o,
   output logic                      overflow_o,
   input  logic                      yumi_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam logic [count_width_p-1:0]  CntMax = '1;
   localparam logic [count_width_p-1:0]  CntOne = count_width_p'(1);
   localparam logic [window_width_p-1:0] WinOne = window_width_p'(1);

   state_e state_q, state_d;

   logic sync1_q, sync2_q, prev_q;
   logic edge_pulse;

   logic [window_width_p-1:0] win_q, win_d;
   logic [count_width_p-1:0]  cnt_q, cnt_d;
   logic                      ovf_q, ovf_d;

   // Two-flop synchronizer plus a history flop for rising-edge detection.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= clk_monitor_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_pulse = sync2_q & ~prev_q;

   // State, window counter and result registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state logic: load a window, count pulses, hold the result until taken.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               win_d   = window_cycles_i;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (window_cycles_i == '0) ? DONE : MEASURE;
            end
         end
         MEASURE: begin
            if (edge_pulse) begin
               if (cnt_q == CntMax) ovf_d = 1'b1;
               else                 cnt_d = cnt_q + CntOne;
            end
            win_d = win_q - WinOne;
            if (win_q == WinOne) state_d = DONE;
         end
         DONE: begin
            if (yumi_i) begin
`ifdef BSG_CLK_GEN_PEARL_MONITOR_METER_CONTINUOUS_EN
               win_d   = window_cycles_i;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (window_cycles_i == '0) ? DONE : MEASURE;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o     = (state_q == MEASURE);
   assign v_o        = (state_q == DONE);
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;

endmodule
